ch_announce_tx: RTL

Cluster-head announcement transmitter for the node datapath. Once the node has decided its role, this block polls the shared transmit-buffer status word in the 2048×8 packet memory. When the buffer is free, it writes a fixed-format announcement packet as 16-bit words, then marks the buffer ready for the radio side. It is the writer counterpart of the cluster-head detection logic, which parses incoming announcements out of the same memory.

---
 rtl/ch_announce_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ch_announce_tx.sv
// ch_announce_tx: polls the tx-buffer status word, writes a cluster-head announcement packet, then marks it ready.
// Define ANNOUNCE_CHECKSUM_EN to append an XOR checksum word (LEN becomes 5).
module ch_announce_tx #(
    parameter logic [10:0] TXBUF_BASE  = 11'h600,
    parameter logic [10:0] STATUS_ADDR = 11'h5FE,
    parameter int          MAX_POLL    = 255
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        en,
    input  logic [15:0] node_id,
    input  logic [15:0] energy,
    input  logic [7:0]  hop_count,
    input  logic        ch_flag,
    input  logic [15:0] data_in,
    output logic [10:0] address,
    output logic        wr_en,
    output logic [15:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        err
);
`ifdef ANNOUNCE_CHECKSUM_EN
    localparam logic [2:0] LAST = 3'd4;
`else
    localparam logic [2:0] LAST = 3'd3;
`endif
    localparam logic [7:0] LEN = 8'(LAST) + 8'd1;
    localparam int CW = $clog2(MAX_POLL + 1);

    typedef enum logic [2:0] {IDLE, POLL, WAIT, WRITE, STATUS, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d, nidx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   nid_q, nid_d, eng_q, eng_d;
    logic [7:0]    hop_q, hop_d;
    logic          chf_q, chf_d;
    logic [10:0]   addr_d;
    logic [15:0]   dout_d;
    logic          wr_d, busy_d, done_d, err_d;
    logic [15:0]   w0, w3, word;

    assign w0   = {8'hC1, LEN};
    assign w3   = {hop_q, 7'b0, chf_q};
    // index of the word placed on the bus at the coming edge
    assign nidx = (state_q == WAIT) ? 3'd0 : idx_q + 3'd1;
`ifdef ANNOUNCE_CHECKSUM_EN
    assign word = (nidx == 3'd0) ? w0 : (nidx == 3'd1) ? nid_q : (nidx == 3'd2) ? eng_q :
                  (nidx == 3'd3) ? w3 : w0 ^ nid_q ^ eng_q ^ w3;
`else
    assign word = (nidx == 3'd0) ? w0 : (nidx == 3'd1) ? nid_q : (nidx == 3'd2) ? eng_q : w3;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        nid_d   = nid_q;
        eng_d   = eng_q;
        hop_d   = hop_q;
        chf_d   = chf_q;
        addr_d  = address;
        dout_d  = data_out;
        wr_d    = 1'b0;
        err_d   = err;
        case (state_q)
            IDLE: if (en) begin
                nid_d   = node_id;
                eng_d   = energy;
                hop_d   = hop_count;
                chf_d   = ch_flag;
                cnt_d   = '0;
                err_d   = 1'b0;
                addr_d  = STATUS_ADDR;
                state_d = POLL;
            end
            POLL: state_d = WAIT;
            WAIT: if (data_in == 16'h0000) begin
                state_d = WRITE;
                idx_d   = 3'd0;
                wr_d    = 1'b1;
                addr_d  = TXBUF_BASE;
                dout_d  = word;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                err_d   = (cnt_d == CW'(MAX_POLL));
                state_d = err_d ? DONE : POLL;
            end
            WRITE: begin
                wr_d = 1'b1;
                if (idx_q == LAST) begin
                    state_d = STATUS;
                    addr_d  = STATUS_ADDR;
                    dout_d  = 16'h0001;
                end else begin
                    idx_d  = nidx;
                    addr_d = TXBUF_BASE + {7'b0, nidx, 1'b0};
                    dout_d = word;
                end
            end
            STATUS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            nid_q    <= '0;
            eng_q    <= '0;
            hop_q    <= '0;
            chf_q    <= 1'b0;
            address  <= '0;
            data_out <= '0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            nid_q    <= nid_d;
            eng_q    <= eng_d;
            hop_q    <= hop_d;
            chf_q    <= chf_d;
            address  <= addr_d;
            data_out <= dout_d;
            wr_en    <= wr_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
        end
    end
endmodule
